trap_controller: RTL
====================

# trap_controller

Machine-mode trap sequencer between the pipeline commit point and the CSR register file. It samples interrupt lines and exceptions, accepts at most one event at a time, and stalls and flushes the pipeline. It then writes MEPC, MCAUSE and MSTATUS through the CSR write port in a fixed multi-cycle sequence and redirects fetch to the trap vector. MRET is handled by the same block: it restores MSTATUS and redirects to MEPC.

## Interface
Parameters:
- VECTORED, 1: when 1, and MTVEC[1:0]==2'b01, interrupts vector to base + 4×code; exceptions always go to base.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- irq_ext  in  1  external interrupt, level.
- irq_timer  in  1  timer interrupt, level.
- irq_sw  in  1  software interrupt, level.
- exc_valid  in  1  synchronous exception at commit.
- exc_cause  in  4  exception code (2 illegal, 3 ebreak, 11 ecall).
- exc_pc  in  32  PC of the faulting instruction.
- is_mret  in  1  MRET at commit.
- pc  in  32  PC of the instruction currently at commit.
- pc_valid  in  1  `pc` holds a real instruction.
- mstatus, mie, mtvec, mepc  in  32 each  current CSR contents.
- csr_we  out  1  CSR write strobe.
- csr_waddr  out  12  CSR address.
- csr_wdata  out  32  CSR write data.
- mip  out  32  pending bits: [11] ext, [7] timer, [3] sw; all other bits 0.
- stall  out  1  freeze the pipeline.
- flush  out  1  one-cycle pipeline squash.
- redirect  out  1  one-cycle fetch redirect.
- redirect_pc  out  32  redirect target.
- busy  out  1  FSM not in IDLE.

## Operation
- **mip register.** Each cycle, mip <= {irq_ext, irq_timer, irq_sw} placed at bits 11/7/3. Interrupt decisions use the registered mip, which gives one cycle of sync latency.
- **Interrupt take condition.** enabled = mip & mie; an interrupt is taken only if mstatus[3] && pc_valid && enabled != 0.
- **Priority in IDLE:**
  - exc_valid first.
  - is_mret second.
  - Interrupts last, ordered ext (code 11) > sw (3) > timer (7).
- **Effect of priority.** Losing sources are not latched. Interrupts are level-sensitive and are re-evaluated on the next IDLE cycle.
- **Accept.** In IDLE, when an event is accepted, latch:
  - cause: {1'b1, 27'b0, code} for an interrupt; {28'b0, exc_cause} for an exception.
  - epc: exc_pc for an exception; pc for an interrupt. Bits [1:0] are forced to 0.
  - a trap/mret flag.
- **FSM states:** IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_STATUS, MRET_STATUS, REDIRECT.
  - Trap path: IDLE → SAVE_EPC → SAVE_CAUSE → SAVE_STATUS → REDIRECT → IDLE.
  - MRET path: IDLE → MRET_STATUS → REDIRECT → IDLE.
- **CSR writes.** csr_we=1 only in the SAVE_* and MRET_STATUS states:
  - SAVE_EPC: address 0x341, data = epc.
  - SAVE_CAUSE: address 0x342, data = cause.
  - SAVE_STATUS: address 0x300, data = mstatus with bit 7 (MPIE) set to the old bit 3, bit 3 (MIE) = 0, bits [12:11] (MPP) = 2'b11. All other bits pass through unchanged.
  - MRET_STATUS: address 0x300, data = mstatus with bit 3 set to the old bit 7, bit 7 = 1, bits [12:11] = 2'b11.
- **REDIRECT state.** redirect=1.
  - MRET: redirect_pc = mepc input sampled in this state.
  - Trap: redirect_pc = {mtvec[31:2], 2'b00}, plus (code<<2) when the event is an interrupt, VECTORED=1 and mtvec[1:0]==2'b01. Addition is 32-bit modulo, with no overflow detection.
- **Output rules:**
  - flush=1 only in the first state after accept (SAVE_EPC or MRET_STATUS).
  - stall = busy = (state != IDLE).
  - Outside the write states: csr_we=0, csr_waddr=0, csr_wdata=0.
  - Outside REDIRECT: redirect_pc=0.
- **Inputs ignored while busy.** exc_valid, is_mret and interrupts are not sampled when busy=1; the pipeline is frozen then.
- **No nesting.** After a trap, MIE=0 in the CSR file, so there is no re-entry until MRET or a software write.

## Timing
- **Reset.** rst sampled high at a posedge: state=IDLE, mip=0, and all outputs are 0 from that edge. This applies mid-sequence too: a partially written sequence is abandoned, with no further CSR writes and no redirect.
- **Trap timeline.** Accept at edge N. Cycle N+1: SAVE_EPC with flush. N+2: SAVE_CAUSE. N+3: SAVE_STATUS. N+4: REDIRECT. N+5: IDLE, with a new accept possible at the end of N+5.
- **MRET timeline.** Accept at edge N. N+1: MRET_STATUS with flush. N+2: REDIRECT. N+3: IDLE.
- **Interrupt latency.** An irq line rising before edge M updates mip at M; the earliest accept is edge M+1.
- **MSTATUS bypass.** The CSR file is expected to write in the same cycle as csr_we. mstatus read in SAVE_STATUS reflects the pre-trap value, because no earlier step wrote 0x300.

## Test plan
- **Exception.** exc_valid=1, exc_cause=2, exc_pc=0x100, mtvec=0x200 → writes: 0x341←0x100, 0x342←0x2, 0x300 with MIE cleared and MPIE=old MIE. Then redirect_pc=0x200 at cycle N+4; flush only at N+1.
- **Vectored timer interrupt.** mstatus=0x8, mie=0x80, irq_timer=1, mtvec=0x201, pc=0x40 → mip=0x80. Writes: mcause=0x80000007, mepc=0x40. redirect_pc=0x21C; written mstatus=0x1880.
- **MRET.** mstatus=0x80, mepc=0x44 → written mstatus=0x1888; redirect_pc=0x44 at N+2. busy is 0 at N+3.
- **Priority and masking:**
  - exc_valid, is_mret and irq_ext asserted together → exception sequence runs; MRET is dropped.
  - With mstatus[3]=0 → no interrupt is taken.
  - irq_sw and irq_timer both enabled → mcause code 3 (sw wins over timer).
- **Masking by pc_valid.** pc_valid=0 with an enabled interrupt → no accept until pc_valid=1.
- **Reset mid-operation.** Assert rst during SAVE_CAUSE → next cycle busy=0 and csr_we=0, with no redirect. A new exception is then accepted normally.

Source files
------------

// File: rtl/trap_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : trap_controller_if
//  Description : CSR-side bundle of the machine-mode trap sequencer. It holds
//                the current CSR contents read by the sequencer, the CSR write
//                port it drives, and the registered pending-interrupt bits.
//  Ports       : mstatus, mie, mtvec, mepc  - CSR contents (to sequencer)
//                csr_we, csr_waddr, csr_wdata - CSR write port (from sequencer)
//                mip                          - pending bits (from sequencer)
//  Revision    : 1.0 - initial release
// ============================================================================
interface trap_controller_if;
  logic [31:0] mstatus;
  logic [31:0] mie;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic [31:0] mip;

  // Trap sequencer side
  modport master (
    input  mstatus, mie, mtvec, mepc,
    output csr_we, csr_waddr, csr_wdata, mip
  );

  // CSR register file side
  modport slave (
    output mstatus, mie, mtvec, mepc,
    input  csr_we, csr_waddr, csr_wdata, mip
  );
endinterface
`default_nettype wire

// File: rtl/trap_controller.sv
`default_nettype none
// ============================================================================
//  Module      : trap_controller
//  Description : Machine-mode trap sequencer. Accepts one exception, MRET or
//                interrupt at a time from IDLE, stalls/flushes the pipeline,
//                writes MEPC/MCAUSE/MSTATUS in a fixed sequence and redirects
//                fetch to the trap vector (or to MEPC for MRET).
//  Ports       : clk, rst                 - clock, sync active-high reset
//                irq_ext/irq_timer/irq_sw - level interrupt lines
//                exc_valid/exc_cause/exc_pc - commit-point exception
//                is_mret                  - MRET at commit
//                pc/pc_valid              - instruction at commit
//                csr                      - CSR bundle (trap_controller_if)
//                stall/flush/redirect/redirect_pc/busy - pipeline control
//  Revision    : 1.0 - initial release
// ============================================================================
module trap_controller #(
  parameter bit VECTORED = 1'b1
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     irq_ext,
  input  wire logic                     irq_timer,
  input  wire logic                     irq_sw,
  input  wire logic                     exc_valid,
  input  wire logic [3:0]               exc_cause,
  input  wire logic [31:0]              exc_pc,
  input  wire logic                     is_mret,
  input  wire logic [31:0]              pc,
  input  wire logic                     pc_valid,
  trap_controller_if.master             csr,
  output logic                          stall,
  output logic                          flush,
  output logic                          redirect,
  output logic [31:0]                   redirect_pc,
  output logic                          busy
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_SAVE_EPC    = 3'd1;
  localparam logic [2:0] S_SAVE_CAUSE  = 3'd2;
  localparam logic [2:0] S_SAVE_STATUS = 3'd3;
  localparam logic [2:0] S_MRET_STATUS = 3'd4;
  localparam logic [2:0] S_REDIRECT    = 3'd5;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [31:0] pending;
  logic [31:0] saved_cause;
  logic [31:0] saved_epc;
  logic        saved_mret;

  logic [31:0] enabled;
  logic        irq_take;
  logic [3:0]  irq_code;
  logic        acc_exc;
  logic        acc_mret;
  logic        acc_irq;
  logic        vec_en;
  logic [31:0] trap_target;

  // Registered pending bits: interrupt decisions see one cycle of latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 32'd0;
    end else begin
      pending <= {20'd0, irq_ext, 3'd0, irq_timer, 3'd0, irq_sw, 3'd0};
    end
  end

  assign csr.mip = pending;

  // Event selection in IDLE: exception > MRET > interrupt (ext > sw > timer).
  assign enabled  = pending & csr.mie;
  assign irq_take = csr.mstatus[3] && pc_valid && (enabled != 32'd0);
  assign irq_code = enabled[11] ? 4'd11 : (enabled[3] ? 4'd3 : 4'd7);
  assign acc_exc  = exc_valid;
  assign acc_mret = !exc_valid && is_mret;
  assign acc_irq  = !exc_valid && !is_mret && irq_take;

  // Event context captured only on accept; busy cycles leave it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      saved_cause <= 32'd0;
      saved_epc   <= 32'd0;
      saved_mret  <= 1'b0;
    end else if (state == S_IDLE) begin
      if (acc_exc) begin
        saved_cause <= {28'd0, exc_cause};
        saved_epc   <= {exc_pc[31:2], 2'b00};
        saved_mret  <= 1'b0;
      end else if (acc_mret) begin
        saved_mret  <= 1'b1;
      end else if (acc_irq) begin
        saved_cause <= {1'b1, 27'd0, irq_code};
        saved_epc   <= {pc[31:2], 2'b00};
        saved_mret  <= 1'b0;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (acc_exc || acc_irq) begin
          state_nxt = S_SAVE_EPC;
        end else if (acc_mret) begin
          state_nxt = S_MRET_STATUS;
        end
      end
      S_SAVE_EPC:    state_nxt = S_SAVE_CAUSE;
      S_SAVE_CAUSE:  state_nxt = S_SAVE_STATUS;
      S_SAVE_STATUS: state_nxt = S_REDIRECT;
      S_MRET_STATUS: state_nxt = S_REDIRECT;
      S_REDIRECT:    state_nxt = S_IDLE;
      default:       state_nxt = S_IDLE;
    endcase
  end

  // Vectoring applies to interrupts only, and only in vectored MTVEC mode.
  assign vec_en      = VECTORED && saved_cause[31] && (csr.mtvec[1:0] == 2'b01);
  assign trap_target = {csr.mtvec[31:2], 2'b00} +
                       (vec_en ? {26'd0, saved_cause[3:0], 2'b00} : 32'd0);

  // Output logic
  always_comb begin
    csr.csr_we    = 1'b0;
    csr.csr_waddr = 12'd0;
    csr.csr_wdata = 32'd0;
    flush         = 1'b0;
    redirect      = 1'b0;
    redirect_pc   = 32'd0;
    busy          = (state != S_IDLE);
    stall         = (state != S_IDLE);
    case (state)
      S_SAVE_EPC: begin
        flush         = 1'b1;
        csr.csr_we    = 1'b1;
        csr.csr_waddr = ADDR_MEPC;
        csr.csr_wdata = saved_epc;
      end
      S_SAVE_CAUSE: begin
        csr.csr_we    = 1'b1;
        csr.csr_waddr = ADDR_MCAUSE;
        csr.csr_wdata = saved_cause;
      end
      S_SAVE_STATUS: begin
        // MPIE <= MIE, MIE <= 0, MPP <= M; mstatus is still pre-trap here.
        csr.csr_we    = 1'b1;
        csr.csr_waddr = ADDR_MSTATUS;
        csr.csr_wdata = {csr.mstatus[31:13], 2'b11, csr.mstatus[10:8],
                         csr.mstatus[3], csr.mstatus[6:4], 1'b0,
                         csr.mstatus[2:0]};
      end
      S_MRET_STATUS: begin
        // MIE <= MPIE, MPIE <= 1, MPP <= M.
        flush         = 1'b1;
        csr.csr_we    = 1'b1;
        csr.csr_waddr = ADDR_MSTATUS;
        csr.csr_wdata = {csr.mstatus[31:13], 2'b11, csr.mstatus[10:8],
                         1'b1, csr.mstatus[6:4], csr.mstatus[7],
                         csr.mstatus[2:0]};
      end
      S_REDIRECT: begin
        redirect    = 1'b1;
        redirect_pc = saved_mret ? csr.mepc : trap_target;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire
